// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: receiver state encoding and byte framing constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    I2C_RX_IDLE = 3'd0,
    I2C_RX_ADDR = 3'd1,
    I2C_RX_AACK = 3'd2,
    I2C_RX_DATA = 3'd3,
    I2C_RX_DACK = 3'd4
  } i2c_rx_state_t;

  localparam logic [6:0] I2C_GCALL_ADDR    = 7'h00;
  localparam int         I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_rx_shift.sv
// Serial-to-parallel shifter: MSB-first shift on each enabled SCL rise, with a
// bit counter that saturates at one byte so stray SCL rises cannot wrap it.
module i2c_rx_shift
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift,
  input  logic       sda,
  output logic [7:0] sr,
  output logic       last,
  output logic       done
);

  localparam logic [3:0] BCNT_FULL = 4'(I2C_BITS_PER_BYTE);

  logic [3:0] bcnt;

  assign done = (bcnt == BCNT_FULL);
  assign last = (bcnt == BCNT_FULL - 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (clr) begin
      bcnt <= '0;
    end else if (shift && !done) begin
      sr   <= {sr[6:0], sda};
      bcnt <= bcnt + 4'd1;
    end
  end

endmodule

// File: rtl/i2c_byte_rx.sv
// I2C slave write receiver: frames address/data bytes, matches ADDR, drives ACK, strobes data bytes out.
// Define I2C_BYTE_RX_GCALL_EN to also accept the general-call address 7'h00 (write).
module i2c_byte_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda,
  input  logic       scl_lohi,
  input  logic       scl_hilo,
  input  logic       sta,
  input  logic       sto,
  input  logic       full,
  output logic       sda_low,
  output logic [7:0] dat,
  output logic       dat_vld,
  output logic       sel
);

  i2c_rx_state_t state;
  logic [7:0]    sr;
  logic          last;
  logic          done;
  logic          ack_ok;
  logic          hilo;
  logic          shift;
  logic          clr;
  logic          match;

  // A falling-edge pulse coincident with a rising-edge pulse is treated as noise.
  assign hilo  = scl_hilo & ~scl_lohi;
  assign shift = scl_lohi & ~sta & ~sto &
                 ((state == I2C_RX_ADDR) | (state == I2C_RX_DATA));
  assign clr   = sta | (hilo & ~sto &
                 ((state == I2C_RX_AACK) | (state == I2C_RX_DACK)));

`ifdef I2C_BYTE_RX_GCALL_EN
  assign match = ~sr[0] & ((sr[7:1] == ADDR) | (sr[7:1] == I2C_GCALL_ADDR));
`else
  assign match = ~sr[0] & (sr[7:1] == ADDR);
`endif

  i2c_rx_shift u_shift (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift (shift),
    .sda   (sda),
    .sr    (sr),
    .last  (last),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= I2C_RX_IDLE;
      sda_low <= 1'b0;
      dat     <= 8'h00;
      dat_vld <= 1'b0;
      sel     <= 1'b0;
      ack_ok  <= 1'b0;
    end else begin
      dat_vld <= 1'b0;
      if (sta) begin
        state   <= I2C_RX_ADDR;
        sda_low <= 1'b0;
        sel     <= 1'b0;
      end else if (sto) begin
        state   <= I2C_RX_IDLE;
        sda_low <= 1'b0;
        sel     <= 1'b0;
      end else begin
        case (state)
          I2C_RX_IDLE: ;
          I2C_RX_ADDR: begin
            if (hilo && done) begin
              if (match) begin
                sda_low <= 1'b1;
                state   <= I2C_RX_AACK;
              end else begin
                state   <= I2C_RX_IDLE;
              end
            end
          end
          I2C_RX_AACK: begin
            if (hilo) begin
              sda_low <= 1'b0;
              sel     <= 1'b1;
              state   <= I2C_RX_DATA;
            end
          end
          I2C_RX_DATA: begin
            // A full buffer still gets the byte; only the ACK reflects it.
            if (scl_lohi && last) begin
              dat     <= {sr[6:0], sda};
              dat_vld <= 1'b1;
              ack_ok  <= ~full;
            end else if (hilo && done) begin
              sda_low <= ack_ok;
              state   <= I2C_RX_DACK;
            end
          end
          I2C_RX_DACK: begin
            if (hilo) begin
              sda_low <= 1'b0;
              state   <= I2C_RX_DATA;
            end
          end
          default: state <= I2C_RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_rx.sv
// Self-checking bench for i2c_byte_rx: fixed transaction table, corner-case sequences,
// and random transactions scored against a byte-level model of the slave.
module tb_i2c_byte_rx;

  localparam logic [6:0] SLV = 7'h50;
`ifdef I2C_BYTE_RX_GCALL_EN
  localparam bit GCALL = 1'b1;
`else
  localparam bit GCALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sda = 1'b1;
  logic       scl_lohi = 1'b0;
  logic       scl_hilo = 1'b0;
  logic       sta = 1'b0;
  logic       sto = 1'b0;
  logic       full = 1'b0;
  logic       sda_low;
  logic [7:0] dat;
  logic       dat_vld;
  logic       sel;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         m_addr;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         f;
    bit         e_aack;
    bit         e_dack;
    bit         e_sel;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  i2c_byte_rx #(.ADDR(SLV)) dut (
    .clk      (clk),
    .rst      (rst),
    .sda      (sda),
    .scl_lohi (scl_lohi),
    .scl_hilo (scl_hilo),
    .sta      (sta),
    .sto      (sto),
    .full     (full),
    .sda_low  (sda_low),
    .dat      (dat),
    .dat_vld  (dat_vld),
    .sel      (sel)
  );

  always @(negedge clk) if (rst && dat_vld) got_q.push_back(dat);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_lohi();
    scl_lohi = 1'b1; cyc(1); scl_lohi = 1'b0;
  endtask

  task automatic pulse_hilo();
    scl_hilo = 1'b1; cyc(1); scl_hilo = 1'b0;
  endtask

  task automatic do_start();
    m_addr = 1'b0;
    sta = 1'b1; cyc(1); sta = 1'b0; cyc(1);
  endtask

  task automatic do_stop();
    m_addr = 1'b0;
    sto = 1'b1; cyc(1); sto = 1'b0; cyc(1);
    chk("sel_after_stop", sel, 0);
  endtask

  // One bit: SDA set up while SCL low, rise, high time, fall. Extra rises model SCL glitches.
  task automatic send_bit(input logic b, input bit f, input int extra, output bit vld_now);
    sda = b; full = f; cyc(1);
    pulse_lohi();
    vld_now = dat_vld;
    full = 1'b0;
    for (int k = 0; k < extra; k++) begin
      sda = ~sda; cyc(1); pulse_lohi();
    end
    cyc(2); pulse_hilo(); cyc(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit f, input int extra,
                           output bit vld_now, output bit ack);
    bit v;
    vld_now = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], (i == 0) ? f : 1'b0, (i == 0) ? extra : 0, v);
      if (i == 0) vld_now = v;
    end
    sda = 1'b1; cyc(1); pulse_lohi(); cyc(1);
    ack = sda_low;
    pulse_hilo();
    chk("ack_release", sda_low, 0);
  endtask

  task automatic xfer_addr(input logic [7:0] b);
    bit v, a, e;
    e = (b == {SLV, 1'b0}) || (GCALL && b == 8'h00);
    send_byte(b, 1'b0, 0, v, a);
    chk("addr_ack", a, e);
    chk("addr_no_vld", v, 0);
    m_addr = e;
    chk("sel_after_addr", sel, m_addr);
  endtask

  task automatic xfer_data(input logic [7:0] b, input bit f, input int extra);
    bit v, a;
    if (m_addr) exp_q.push_back(b);
    send_byte(b, f, extra, v, a);
    chk("data_ack", a, m_addr && !f);
    chk("data_vld_latency", v, m_addr);
    chk("sel_during_data", sel, m_addr);
  endtask

  task automatic check_deliv(input string name);
    chk(name, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("deliv_byte", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit v, a;
    logic [7:0] ab;
    int n;

    tbl[0] = '{8'hA0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{8'hA2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'hA1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hA0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'hA0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h77, 1'b0, GCALL, GCALL, GCALL};
    tbl[6] = '{8'hA0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{8'h20, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0};

    cyc(3);
    chk("rst_sda_low", sda_low, 0);
    chk("rst_dat", dat, 8'h00);
    chk("rst_dat_vld", dat_vld, 0);
    chk("rst_sel", sel, 0);
    rst = 1'b1;
    cyc(2);

    // Bytes without a START must be ignored.
    send_byte(8'hA0, 1'b0, 0, v, a);
    chk("idle_no_ack", a, 0);

    for (int t = 0; t < 8; t++) begin
      got_q.delete();
      do_start();
      send_byte(tbl[t].addr, 1'b0, 0, v, a);
      chk("tbl_addr_ack", a, tbl[t].e_aack);
      chk("tbl_sel", sel, tbl[t].e_sel);
      send_byte(tbl[t].data, tbl[t].f, 0, v, a);
      chk("tbl_data_ack", a, tbl[t].e_dack);
      chk("tbl_vld", v, tbl[t].e_sel);
      do_stop();
      chk("tbl_deliv_cnt", got_q.size(), tbl[t].e_sel ? 1 : 0);
      if (tbl[t].e_sel && got_q.size() > 0) chk("tbl_deliv_dat", got_q[0], tbl[t].data);
    end
    got_q.delete();

    // Back-pressure then recovery inside one transaction.
    do_start();
    xfer_addr(8'hA0);
    xfer_data(8'h99, 1'b1, 0);
    xfer_data(8'h11, 1'b0, 0);
    do_stop();
    check_deliv("bp_deliv");

    // Repeated START after four data bits.
    do_start();
    xfer_addr(8'hA0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1, 1'b0, 0, v);
    do_start();
    chk("rs_no_vld", got_q.size(), 0);
    xfer_addr(8'hA0);
    xfer_data(8'h5A, 1'b0, 0);
    do_stop();
    check_deliv("rs_deliv");

    // Stray SCL rises after the 8th bit must not shift or re-strobe.
    do_start();
    xfer_addr(8'hA0);
    xfer_data(8'hC3, 1'b0, 2);
    do_stop();
    check_deliv("sat_deliv");

    // Asynchronous reset while the address ACK is being driven.
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(ab[0] ^ ab[0] ^ ((8'hA0 >> i) & 1), 1'b0, 0, v);
    chk("ack_before_rst", sda_low, 1);
    #2 rst = 1'b0;
    #1 chk("async_release", sda_low, 0);
    chk("rst_mid_sel", sel, 0);
    chk("rst_mid_dat", dat, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    m_addr = 1'b0;
    cyc(1);
    send_byte(8'hA0, 1'b0, 0, v, a);
    chk("post_rst_idle", a, 0);
    do_start();
    xfer_addr(8'hA0);
    xfer_data(8'h42, 1'b0, 0);
    do_stop();
    do_start();
    xfer_addr(8'h00);
    xfer_data(8'h24, 1'b0, 0);
    do_stop();
    check_deliv("post_rst_deliv");

    for (int t = 0; t < 30; t++) begin
      do_start();
      case ($urandom_range(0, 3))
        0: ab = 8'hA0;
        1: ab = 8'hA1;
        2: ab = 8'h00;
        default: ab = 8'($urandom);
      endcase
      xfer_addr(ab);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) xfer_data(8'($urandom), ($urandom_range(0, 3) == 0), 0);
      if ($urandom_range(0, 4) != 0) do_stop();
      check_deliv("rand_deliv");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_byte_rx.md
# i2c_byte_rx

Slave-side I2C write receiver. It sits directly downstream of `i2c_edge_detect`/`i2c_bby_detect` and consumes their single-cycle `sta`/`sto` pulses and the SCL edge pulses. It frames the serial stream into an address byte and data bytes, matches the 7-bit slave address, and drives the ACK bit. Received data bytes are handed out as single-cycle strobes to a downstream buffer.

## Interface
Parameters:
- `ADDR`, default 7'h50: 7-bit slave address.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `sda` in 1: SDA level, already synchronous to `clk`.
- `scl_lohi` in 1: one-cycle pulse on an SCL 0->1 transition.
- `scl_hilo` in 1: one-cycle pulse on an SCL 1->0 transition.
- `sta` in 1: one-cycle START / repeated-START pulse.
- `sto` in 1: one-cycle STOP pulse.
- `full` in 1: downstream buffer cannot take a byte.
- `sda_low` out 1: 1 = pull SDA low (open-drain driver enable).
- `dat` out 8: last received data byte.
- `dat_vld` out 1: one-cycle strobe; `dat` is valid.
- `sel` out 1: 1 while this slave is addressed (from address ACK until STOP or START).

## Operation
- The state machine has five states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK.
- A 4-bit bit counter `bcnt` and an 8-bit shift register `sr` are used. On `scl_lohi`, `sr <= {sr[6:0], sda}` (MSB first) and `bcnt <= bcnt+1`.
- `sta` in any state:
  - go to ADDR, `bcnt <= 0`, `sda_low <= 0`, `sel <= 0`.
  - `sta` has priority over every SCL pulse in the same cycle.
- `sto` in any state: go to IDLE, `sda_low <= 0`, `sel <= 0`. Priority is `sta` > `sto` > SCL pulses.
- IDLE: all SCL pulses are ignored.
- ADDR, when `bcnt==8` on `scl_hilo`:
  - Match means `sr[7:1]==ADDR` and `sr[0]==0` (write). Reads are unsupported and count as a mismatch.
  - On match: `sda_low <= 1`, go to ADDR_ACK.
  - On mismatch: go to IDLE. The block stays deaf until the next `sta`.
- ADDR_ACK, on `scl_hilo` (end of the 9th clock): `sda_low <= 0`, `sel <= 1`, `bcnt <= 0`, go to DATA.
- DATA:
  - On the `scl_lohi` that brings `bcnt` to 8: `dat <= {sr[6:0], sda}` and `dat_vld` pulses for one cycle in the next cycle. The ACK decision latches `ack_ok <= !full` in the same cycle.
  - When `bcnt==8`, on `scl_hilo`: `sda_low <= ack_ok`, go to DATA_ACK.
  - When `full` is sampled high, the byte is still strobed and NACKed. The downstream side must drop it.
- DATA_ACK, on `scl_hilo`: `sda_low <= 0`, `bcnt <= 0`, go to DATA.
- The counter saturates at 8. Extra `scl_lohi` pulses while `bcnt==8` do not wrap or shift.
- SDA is sampled only on `scl_lohi`. SDA changes while SCL is high are START/STOP, not data.

## Timing
- Reset values: state IDLE, `bcnt=0`, `sr=0`, `dat=8'h00`, `dat_vld=0`, `sda_low=0`, `sel=0`.
- Reset asserted mid-byte or during ACK releases `sda_low` immediately (asynchronous clear).
- `dat_vld` latency: 1 `clk` after the 8th-bit `scl_lohi` pulse.
- `sda_low` asserts 1 `clk` after the 8th `scl_hilo` pulse and deasserts 1 `clk` after the 9th.
- All outputs are registered. No combinational path from inputs to outputs.
- A simultaneous `scl_hilo` and `scl_lohi` pulse cannot occur; if it does, `scl_hilo` is ignored.

## Configuration
- `I2C_BYTE_RX_GCALL_EN` defined:
  - Address 7'h00 with W=0 also matches and is ACKed. `sel` asserts as for `ADDR`.
  - Data bytes of a general call are delivered the same way.
- `I2C_BYTE_RX_GCALL_EN` undefined: 7'h00 is a mismatch and is NACKed (no `sda_low`).

## Structure
- The shared package `i2c_pkg` holds:
  - the state encoding (`I2C_RX_IDLE`..`I2C_RX_DACK`, 3 bits),
  - `I2C_GCALL_ADDR` = 7'h00,
  - `I2C_BITS_PER_BYTE` = 8.
- One natural sub-module: `i2c_rx_shift`, holding the shift register, saturating bit counter and byte-complete flag, with a clear input.
- The FSM and ACK logic stay in the top module.

## Test plan
- Address write: START, 0xA0 (ADDR 7'h50, W), data 0x3C, STOP. Expect `sda_low` high during the 9th clock of both bytes, one `dat_vld` with `dat=0x3C`, `sel` 1 until STOP.
- Address mismatch: START, 0xA2, data 0x55, STOP. Expect `sda_low` never asserted, no `dat_vld`, `sel` stays 0.
- Read request: START, 0xA1. Expect NACK (`sda_low` 0), back to IDLE.
- Back-pressure: `full=1` during the 8th bit of data byte 0x99. Expect `dat_vld` with 0x99 and `sda_low` 0 on the 9th clock. Next byte 0x11 with `full=0` is ACKed.
- Repeated START mid-data after 4 bits: expect `bcnt` reset, no `dat_vld`, new address byte 0xA0 ACKed.
- Reset mid-ACK (`rst` low while `sda_low=1`): expect `sda_low=0` immediately without a `clk` edge, state IDLE, and 0xA0 ACKed after the next START. With `I2C_BYTE_RX_GCALL_EN` defined, START then 0x00 is also ACKed.
